// File: rtl/arith_nibble_seq.sv
// Nibble-serial sequencer for the 4-bit arithmetic unit: issues a WIDTH-bit ADD/SUB/INC/DEC
// one nibble per clock, LSB first, chaining the unit's carry and assembling the result.
//
// state  | meaning
// S_IDLE | waiting for start; arith unit inputs parked at 0
// S_RUN  | issuing nibble r_idx, capturing the unit's sum and carry
// S_DONE | one-cycle done pulse, result/cout/zero valid
module arith_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_zero,
  output logic             o_au_s2,
  output logic             o_au_s1,
  output logic             o_au_cin,
  output logic [3:0]       o_au_i,
  output logic [3:0]       o_au_j,
  input  logic [3:0]       i_au_sum,
  input  logic             i_au_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic [IW+1:0]    w_base;
  logic [WIDTH-1:0] w_result_next;

  assign w_base = {r_idx, 2'b00};

  // Result with the current nibble merged in; used for the zero flag on the last step.
  always_comb begin
    w_result_next = r_result;
    w_result_next[w_base +: 4] = i_au_sum;
  end

  always_comb begin
    o_au_i   = 4'h0;
    o_au_j   = 4'h0;
    o_au_cin = 1'b0;
    o_au_s2  = 1'b0;
    o_au_s1  = 1'b0;
    if (r_state == S_RUN) begin
      o_au_i   = r_a[w_base +: 4];
      o_au_j   = r_b[w_base +: 4];
      o_au_cin = r_carry;
      o_au_s2  = r_op[1];
      o_au_s1  = r_op[0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_a;
            r_b     <= i_b;
            r_idx   <= '0;
            // SUB and INC start with carry-in 1 (two's complement / +1)
            r_carry <= i_op[1] ^ i_op[0];
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_result_next;
          r_carry  <= i_au_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= i_au_cout;
            r_zero  <= (w_result_next == '0);
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_cout   = r_cout;
  assign o_zero   = r_zero;

endmodule
